// File: rtl/breakout_pkg.sv
// -----------------------------------------------------------------------------
// breakout_pkg
// Shared types and constants for the breakout hit arbiter and block columns.
//   - arb_state_e    : arbiter FSM states (IDLE/ARB/ISSUE/HOLD)
//   - dir_idx_e      : bit index of each direction inside a 4-bit direction
//                      bundle (U/D/L/R); shared with the column modules
//   - DEF_*          : default board geometry and hold-off length
//   - resolve_bounce : turns raw U/D/L/R request bits into bounce commands
// -----------------------------------------------------------------------------
package breakout_pkg;

  localparam int DEF_NUM_COLS     = 10;
  localparam int DEF_TOTAL_BLOCKS = 80;
  localparam int DEF_COOLDOWN     = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HOLD  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    DIR_U = 2'd0,
    DIR_D = 2'd1,
    DIR_L = 2'd2,
    DIR_R = 2'd3
  } dir_idx_e;

  // Opposing requests on one axis cancel each other. Without corner support
  // a surviving vertical bounce wins over the horizontal one.
  function automatic logic [3:0] resolve_bounce(input logic [3:0] req,
                                                input logic       corner_en);
    logic       v_u, v_d, h_l, h_r;
    logic [3:0] res;
    v_u = req[DIR_U] & ~req[DIR_D];
    v_d = req[DIR_D] & ~req[DIR_U];
    h_l = req[DIR_L] & ~req[DIR_R];
    h_r = req[DIR_R] & ~req[DIR_L];
    if (!corner_en && (v_u || v_d)) begin
      h_l = 1'b0;
      h_r = 1'b0;
    end
    res        = '0;
    res[DIR_U] = v_u;
    res[DIR_D] = v_d;
    res[DIR_L] = h_l;
    res[DIR_R] = h_r;
    return res;
  endfunction

endpackage

// File: rtl/breakout_rr_picker.sv
// -----------------------------------------------------------------------------
// breakout_rr_picker
// Purely combinational round-robin find-first. Scans req_i starting at ptr_i,
// wrapping modulo NUM_COLS, and reports the first set position.
// Ports:
//   req_i   in  NUM_COLS  request vector
//   ptr_i   in  IDX_W     search start column (must be < NUM_COLS)
//   idx_o   out IDX_W     winning column
//   valid_o out 1         at least one request present
// -----------------------------------------------------------------------------
module breakout_rr_picker #(
  parameter int NUM_COLS = 10,
  parameter int IDX_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic [NUM_COLS-1:0] req_i,
  input  logic [IDX_W-1:0]    ptr_i,
  output logic [IDX_W-1:0]    idx_o,
  output logic                valid_o
);

  always_comb begin
    int c;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = 0; i < NUM_COLS; i++) begin
      c = int'(ptr_i) + i;
      if (c >= NUM_COLS) c = c - NUM_COLS;
      if (!valid_o && req_i[c]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/breakout_hit_arbiter.sv
// -----------------------------------------------------------------------------
// breakout_hit_arbiter
// Collects per-column bounce requests, picks one column per hit event with
// round-robin fairness, and issues one registered bounce command plus a
// one-hot grant. A hold-off window after each grant suppresses double
// bounces; a block counter flags level clear.
//
// Build option: define BREAKOUT_HIT_ARB_CORNER_EN to let a vertical and a
// horizontal bounce pulse together (corner hit). Undefined: vertical only.
//
// Ports:
//   clk          in  1             system clock
//   reset_n      in  1             async active-low reset
//   game_reset   in  1             sync board restart (active-high)
//   hit_u/d/l/r  in  NUM_COLS      level-sensitive per-column requests
//   grant        out NUM_COLS      one-hot one-cycle grant
//   bounce_*     out 1             one-cycle direction commands
//   busy         out 1             hold-off window active
//   blocks_left  out clog2(TB+1)   blocks still standing
//   level_clear  out 1             no blocks left
// -----------------------------------------------------------------------------
module breakout_hit_arbiter
  import breakout_pkg::*;
#(
  parameter int NUM_COLS     = DEF_NUM_COLS,
  parameter int TOTAL_BLOCKS = DEF_TOTAL_BLOCKS,
  parameter int COOLDOWN     = DEF_COOLDOWN
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              game_reset,
  input  logic [NUM_COLS-1:0]               hit_u,
  input  logic [NUM_COLS-1:0]               hit_d,
  input  logic [NUM_COLS-1:0]               hit_l,
  input  logic [NUM_COLS-1:0]               hit_r,
  output logic [NUM_COLS-1:0]               grant,
  output logic                              bounce_up,
  output logic                              bounce_down,
  output logic                              bounce_left,
  output logic                              bounce_right,
  output logic                              busy,
  output logic [$clog2(TOTAL_BLOCKS+1)-1:0] blocks_left,
  output logic                              level_clear
);

  localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int BL_W  = $clog2(TOTAL_BLOCKS + 1);

`ifdef BREAKOUT_HIT_ARB_CORNER_EN
  localparam logic CORNER_EN = 1'b1;
`else
  localparam logic CORNER_EN = 1'b0;
`endif

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    win_idx_q, win_idx_d;
  logic [3:0]          win_dirs_q, win_dirs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BL_W-1:0]     blocks_q, blocks_d;
  logic [NUM_COLS-1:0] grant_q, grant_d;
  logic [3:0]          bounce_q, bounce_d;
  logic                busy_q, busy_d;
  logic                level_clear_q, level_clear_d;

  logic [NUM_COLS-1:0] col_req;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

  assign col_req = hit_u | hit_d | hit_l | hit_r;

  breakout_rr_picker #(
    .NUM_COLS (NUM_COLS),
    .IDX_W    (IDX_W)
  ) u_picker (
    .req_i   (col_req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch, so no
    // path leaves a variable unassigned and no latch is inferred.
    state_d       = state_q;
    ptr_d         = ptr_q;
    win_idx_d     = win_idx_q;
    win_dirs_d    = win_dirs_q;
    cnt_d         = cnt_q;
    blocks_d      = blocks_q;
    grant_d       = '0;
    bounce_d      = '0;
    // busy and level_clear trail the state/counter by one cycle so they rise
    // the cycle after the ISSUE pulse.
    busy_d        = (state_q == ST_HOLD);
    level_clear_d = (blocks_q == '0);

    if (game_reset) begin
      state_d       = ST_IDLE;
      ptr_d         = '0;
      blocks_d      = BL_W'(TOTAL_BLOCKS);
      busy_d        = 1'b0;
      level_clear_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if ((|col_req) && !level_clear_q) state_d = ST_ARB;
        end
        ST_ARB: begin
          if (pick_valid) begin
            win_idx_d         = pick_idx;
            win_dirs_d[DIR_U] = hit_u[pick_idx];
            win_dirs_d[DIR_D] = hit_d[pick_idx];
            win_dirs_d[DIR_L] = hit_l[pick_idx];
            win_dirs_d[DIR_R] = hit_r[pick_idx];
            state_d           = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          grant_d[win_idx_q] = 1'b1;
          bounce_d           = resolve_bounce(win_dirs_q, CORNER_EN);
          if (blocks_q != '0) blocks_d = blocks_q - BL_W'(1);
          ptr_d   = (win_idx_q == IDX_W'(NUM_COLS - 1)) ? '0
                                                        : win_idx_q + IDX_W'(1);
          cnt_d   = CNT_W'(COOLDOWN - 1);
          state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (cnt_q == '0) state_d = ST_IDLE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      win_idx_q     <= '0;
      win_dirs_q    <= '0;
      cnt_q         <= '0;
      blocks_q      <= BL_W'(TOTAL_BLOCKS);
      grant_q       <= '0;
      bounce_q      <= '0;
      busy_q        <= 1'b0;
      level_clear_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      win_idx_q     <= win_idx_d;
      win_dirs_q    <= win_dirs_d;
      cnt_q         <= cnt_d;
      blocks_q      <= blocks_d;
      grant_q       <= grant_d;
      bounce_q      <= bounce_d;
      busy_q        <= busy_d;
      level_clear_q <= level_clear_d;
    end
  end

  assign grant        = grant_q;
  assign bounce_up    = bounce_q[DIR_U];
  assign bounce_down  = bounce_q[DIR_D];
  assign bounce_left  = bounce_q[DIR_L];
  assign bounce_right = bounce_q[DIR_R];
  assign busy         = busy_q;
  assign blocks_left  = blocks_q;
  assign level_clear  = level_clear_q;

endmodule

// File: tb/tb_breakout_hit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_breakout_hit_arbiter
// Directed bench for breakout_hit_arbiter. Three instances share inputs:
//   a: defaults (80 blocks, hold-off 4096)
//   b: 80 blocks, hold-off 16
//   c: 2 blocks,  hold-off 16
// Inputs change and outputs are sampled on the falling clock edge.
// Bounce bundles below are packed {up, down, left, right}.
// -----------------------------------------------------------------------------
module tb_breakout_hit_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       game_reset;
  logic [9:0] hit_u, hit_d, hit_l, hit_r;

  logic [9:0] grant_a, grant_b, grant_c;
  logic       up_a, dn_a, lf_a, rt_a;
  logic       up_b, dn_b, lf_b, rt_b;
  logic       up_c, dn_c, lf_c, rt_c;
  logic       busy_a, busy_b, busy_c;
  logic [6:0] blocks_a, blocks_b;
  logic [1:0] blocks_c;
  logic       lc_a, lc_b, lc_c;
  logic [3:0] bnc_a, bnc_b, bnc_c;

  assign bnc_a = {up_a, dn_a, lf_a, rt_a};
  assign bnc_b = {up_b, dn_b, lf_b, rt_b};
  assign bnc_c = {up_c, dn_c, lf_c, rt_c};

  int checks_n = 0;
  int errors_n = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  breakout_hit_arbiter u_dut_a (
    .clk(clk), .reset_n(reset_n), .game_reset(game_reset),
    .hit_u(hit_u), .hit_d(hit_d), .hit_l(hit_l), .hit_r(hit_r),
    .grant(grant_a), .bounce_up(up_a), .bounce_down(dn_a),
    .bounce_left(lf_a), .bounce_right(rt_a), .busy(busy_a),
    .blocks_left(blocks_a), .level_clear(lc_a)
  );

  breakout_hit_arbiter #(.NUM_COLS(10), .TOTAL_BLOCKS(80), .COOLDOWN(16)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .game_reset(game_reset),
    .hit_u(hit_u), .hit_d(hit_d), .hit_l(hit_l), .hit_r(hit_r),
    .grant(grant_b), .bounce_up(up_b), .bounce_down(dn_b),
    .bounce_left(lf_b), .bounce_right(rt_b), .busy(busy_b),
    .blocks_left(blocks_b), .level_clear(lc_b)
  );

  breakout_hit_arbiter #(.NUM_COLS(10), .TOTAL_BLOCKS(2), .COOLDOWN(16)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .game_reset(game_reset),
    .hit_u(hit_u), .hit_d(hit_d), .hit_l(hit_l), .hit_r(hit_r),
    .grant(grant_c), .bounce_up(up_c), .bounce_down(dn_c),
    .bounce_left(lf_c), .bounce_right(rt_c), .busy(busy_c),
    .blocks_left(blocks_c), .level_clear(lc_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_hits();
    hit_u = '0; hit_d = '0; hit_l = '0; hit_r = '0;
  endtask

  task automatic do_game_reset();
    @(negedge clk);
    clear_hits();
    game_reset = 1'b1;
    @(negedge clk);
    game_reset = 1'b0;
  endtask

  // Waits up to budget falling edges for a nonzero grant on the selected
  // instance; on timeout g stays zero so the caller's compare fails.
  task automatic wait_grant(input int sel, input int budget,
                            output logic [9:0] g, output logic [3:0] b,
                            output int at);
    g = '0; b = '0; at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      case (sel)
        0:       begin g = grant_a; b = bnc_a; end
        1:       begin g = grant_b; b = bnc_b; end
        default: begin g = grant_c; b = bnc_c; end
      endcase
      if (g != '0) begin
        at = cyc;
        return;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] g;
    logic [3:0] b;
    int         at0, at1, at2, at3, n;
    logic [13:0] acc;
    logic [3:0] corner_exp;

`ifdef BREAKOUT_HIT_ARB_CORNER_EN
    corner_exp = 4'b1001;
`else
    corner_exp = 4'b1000;
`endif

    reset_n = 1'b0;
    game_reset = 1'b0;
    clear_hits();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_grant",  grant_a, 10'h000);
    check("rst_bounce", bnc_a, 4'b0000);
    check("rst_busy",   busy_a, 1'b0);
    check("rst_blocks", blocks_a, 7'd80);
    check("rst_lc",     lc_a, 1'b0);
    check("rst_blocks_c", blocks_c, 2'd2);
    reset_n = 1'b1;

    // Single request: hit_d[3] for two cycles
    @(negedge clk);
    hit_d[3] = 1'b1;
    repeat (2) @(negedge clk);
    hit_d[3] = 1'b0;
    check("single_latency", grant_a, 10'h000);
    @(negedge clk);
    check("single_grant",  grant_a, 10'b0000001000);
    check("single_bounce", bnc_a, 4'b0100);
    check("single_blocks", blocks_a, 7'd79);
    check("single_busy_at_pulse", busy_a, 1'b0);
    @(negedge clk);
    check("single_pulse_width", grant_a, 10'h000);
    n = 0;
    while (busy_a && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("single_busy_len", n, 4096);

    // Fairness on b: cols 2 and 7 requesting continuously
    do_game_reset();
    hit_u[2] = 1'b1;
    hit_l[7] = 1'b1;
    wait_grant(1, 40, g, b, at0);
    check("fair_g0", g, 10'h004);
    check("fair_b0", b, 4'b1000);
    wait_grant(1, 40, g, b, at1);
    check("fair_g1", g, 10'h080);
    check("fair_b1", b, 4'b0010);
    wait_grant(1, 40, g, b, at2);
    check("fair_g2", g, 10'h004);
    wait_grant(1, 40, g, b, at3);
    check("fair_g3", g, 10'h080);
    check("fair_gap01", at1 - at0, 19);
    check("fair_gap12", at2 - at1, 19);
    check("fair_gap23", at3 - at2, 19);

    // Hold-off on b: hit_l[5] pulsed inside HOLD only
    do_game_reset();
    @(negedge clk);
    hit_r[0] = 1'b1;
    repeat (2) @(negedge clk);
    hit_r[0] = 1'b0;
    wait_grant(1, 5, g, b, at0);
    check("hold_first_grant",  g, 10'h001);
    check("hold_first_bounce", b, 4'b0001);
    repeat (3) @(negedge clk);
    hit_l[5] = 1'b1;
    repeat (4) @(negedge clk);
    check("hold_busy", busy_b, 1'b1);
    hit_l[5] = 1'b0;
    acc = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc = acc | {grant_b, bnc_b};
    end
    check("hold_no_pulse", acc, 14'h0000);
    check("hold_blocks", blocks_b, 7'd79);
    check("hold_idle", busy_b, 1'b0);

    // Corner on a
    do_game_reset();
    @(negedge clk);
    hit_u[1] = 1'b1;
    hit_r[1] = 1'b1;
    repeat (2) @(negedge clk);
    clear_hits();
    wait_grant(0, 5, g, b, at0);
    check("corner_grant",  g, 10'h002);
    check("corner_bounce", b, corner_exp);
    do_game_reset();
    @(negedge clk);
    hit_u[4] = 1'b1;
    hit_d[4] = 1'b1;
    hit_l[4] = 1'b1;
    repeat (2) @(negedge clk);
    clear_hits();
    wait_grant(0, 5, g, b, at0);
    check("ud_cancel_grant",  g, 10'h010);
    check("ud_cancel_bounce", b, 4'b0010);

    // Level clear on c
    do_game_reset();
    check("lc_reload", blocks_c, 2'd2);
    @(negedge clk);
    hit_u[0] = 1'b1;
    repeat (2) @(negedge clk);
    hit_u[0] = 1'b0;
    wait_grant(2, 5, g, b, at0);
    check("lc_grant1",  g, 10'h001);
    check("lc_blocks1", blocks_c, 2'd1);
    repeat (25) @(negedge clk);
    hit_u[0] = 1'b1;
    repeat (2) @(negedge clk);
    hit_u[0] = 1'b0;
    wait_grant(2, 5, g, b, at0);
    check("lc_grant2",  g, 10'h001);
    check("lc_blocks0", blocks_c, 2'd0);
    check("lc_not_yet", lc_c, 1'b0);
    @(negedge clk);
    check("lc_rise", lc_c, 1'b1);
    repeat (25) @(negedge clk);
    hit_r[0] = 1'b1;
    acc = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      acc = acc | {grant_c, bnc_c};
      acc[0] = acc[0] | busy_c;
    end
    check("lc_blocked", acc, 14'h0000);
    check("lc_still_clear", lc_c, 1'b1);
    do_game_reset();
    @(negedge clk);
    check("lc_gr_blocks", blocks_c, 2'd2);
    check("lc_gr_lc", lc_c, 1'b0);

    // Reset mid-operation on b: pointer moved to 6 by a grant on col 5
    do_game_reset();
    @(negedge clk);
    hit_l[5] = 1'b1;
    repeat (2) @(negedge clk);
    hit_l[5] = 1'b0;
    wait_grant(1, 5, g, b, at0);
    check("mid_grant", g, 10'h020);
    #2 reset_n = 1'b0;
    #1;
    check("mid_async_grant",  grant_b, 10'h000);
    check("mid_async_bounce", bnc_b, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_blocks", blocks_b, 7'd80);
    @(negedge clk);
    hit_u[2] = 1'b1;
    hit_u[7] = 1'b1;
    wait_grant(1, 10, g, b, at0);
    check("mid_ptr_zero", g, 10'h004);
    clear_hits();
    repeat (3) @(negedge clk);
    check("mid_busy_before", busy_b, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_async_busy", busy_b, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_idle_after", busy_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule

// File: doc/breakout_hit_arbiter.md
# breakout_hit_arbiter

Central hit arbiter between the block-column modules and the ball motion logic. It collects per-column bounce requests (up/down/left/right), picks one column per hit event with round-robin fairness, and issues a single registered bounce command plus a one-hot grant back to the winning column. A hold-off window after each grant prevents double bounces while the ball still overlaps a block edge. It also tracks blocks remaining and flags level clear.

## Interface
Parameters:
- NUM_COLS, 10: number of block columns arbitrated.
- TOTAL_BLOCKS, 80: blocks on a fresh board; reload value of blocks_left.
- COOLDOWN, 4096: hold-off length in clk cycles after each grant; legal range is 1 or more.

Ports:
- clk  in  1  pixel/system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- game_reset  in  1  synchronous board restart, active-high.
- hit_u / hit_d / hit_l / hit_r  in  NUM_COLS each  per-column registered bounce requests, level-sensitive.
- grant  out  NUM_COLS  one-hot pulse naming the serviced column.
- bounce_up / bounce_down / bounce_left / bounce_right  out  1 each  one-cycle direction commands to ball logic.
- busy  out  1  high while in HOLD.
- blocks_left  out  $clog2(TOTAL_BLOCKS+1)  blocks still standing.
- level_clear  out  1  high while blocks_left == 0.

## Operation
- States: IDLE, ARB, ISSUE, HOLD.
- IDLE:
  - Column c requests when hit_u[c] | hit_d[c] | hit_l[c] | hit_r[c].
  - If any column requests and level_clear is low, go to ARB. Otherwise stay in IDLE.
- ARB:
  - Round-robin search starts at ptr and wraps modulo NUM_COLS. The first requesting column wins.
  - Latch the winning index and that column's four request bits.
  - If no column requests any more, return to IDLE with no output.
  - Go to ISSUE.
- ISSUE, direction resolution:
  - Vertical: U alone → up; D alone → down; both U and D → no vertical.
  - Horizontal resolves the same way for L and R.
  - Without corner support, any vertical direction suppresses the horizontal one.
- ISSUE, actions:
  - Pulse grant[c] and the resolved bounce_* outputs for exactly one cycle.
  - Decrement blocks_left, saturating at 0.
  - Set ptr = (c+1) mod NUM_COLS.
  - Load the cooldown counter with COOLDOWN-1 and go to HOLD.
- HOLD:
  - Requests are ignored.
  - The counter decrements each cycle; at 0, go to IDLE.
- game_reset takes priority over every state action. It forces:
  - state = IDLE, ptr = 0, blocks_left = TOTAL_BLOCKS;
  - all pulse outputs = 0.
- The same game_reset values apply on reset_n assertion, asynchronously, in any state.

## Timing
- Reset values: grant = 0, all bounce_* = 0, busy = 0, blocks_left = TOTAL_BLOCKS, level_clear = 0, state = IDLE, ptr = 0.
- All outputs are registered; there are no combinational paths from input to output.
- Latency: a request sampled in IDLE at edge k produces grant/bounce pulses in the cycle after edge k+2.
- busy is high for exactly COOLDOWN cycles, starting the cycle after the ISSUE pulse.
- Minimum spacing between two grants is COOLDOWN+3 cycles.
- Requests that drop during HOLD are lost. Requests still held after HOLD are re-arbitrated.
- level_clear rises in the cycle after the ISSUE pulse that brings blocks_left to 0. While it is high, the block stays in IDLE.

## Configuration
- BREAKOUT_HIT_ARB_CORNER_EN defined: the resolved vertical and horizontal directions may pulse in the same cycle (corner hit reverses both axes).
- BREAKOUT_HIT_ARB_CORNER_EN undefined: at most one axis is pulsed, and vertical has priority.

## Structure
- The shared package breakout_pkg holds:
  - the state enum (IDLE/ARB/ISSUE/HOLD);
  - the default NUM_COLS, TOTAL_BLOCKS and COOLDOWN constants;
  - a direction-bit index typedef (U/D/L/R), shared with the column modules.
- One sub-module, breakout_rr_picker: a purely combinational round-robin find-first. Inputs are the request vector and ptr; outputs are the index and a valid flag.

## Test plan
- Single request: after reset, hit_d[3] = 1 for 2 cycles → bounce_down and grant = 10'b0000001000 for one cycle, 3 cycles after the first sampled edge. blocks_left 80 → 79; busy high for 4096 cycles.
- Fairness (COOLDOWN=16): cols 2 and 7 both request continuously → grant order is 2, 7, 2, 7. Grants are spaced exactly 19 cycles apart.
- Hold-off (COOLDOWN=16): hit_l[5] pulsed during HOLD, dropped before HOLD ends → no grant and no bounce pulse; blocks_left unchanged.
- Corner: hit_u[1] and hit_r[1] together → with the macro, bounce_up and bounce_right pulse in the same cycle; without it, only bounce_up. hit_u and hit_d together → no vertical pulse.
- Level clear (TOTAL_BLOCKS=2):
  - Two serviced hits → blocks_left = 0 and level_clear = 1.
  - A further hit_r[0] → no pulses.
  - game_reset → blocks_left = 2, level_clear = 0.
- Reset mid-operation: reset_n low during HOLD → busy, grant and bounce_* go to 0 before the next edge; after release, state is IDLE and ptr = 0.
